reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Power-up/recovery sequencer that owns the order in which per-domain sync resets are released.
//  Waits for a filtered PLL lock, then releases NUM_STAGES resets one at a time; each stage is released only after the previous stage reports ready.
//  Re-enters full reset on loss of lock or a software request. Flags a fault on a ready timeout or a ready drop.
//  Sits beside the per-domain reset synchronisers and drives their reset-hold inputs.
// PARAMETERS
//  NUM_STAGES        4      number of sequenced reset outputs, 1..16; stage 0 is released first
//  LOCK_FILTER_CLKS  8      consecutive i_pll_locked=1 cycles needed to accept lock, >=1
//  SETTLE_CLKS       16     cycles between accepted lock and the stage-0 release, >=0
//  TIMEOUT_CLKS      65535  cycles a released stage has to assert ready, >=1
// PORTS
//  i_clk            in   1                   sequencer clock, free-running reference domain
//  i_ext_arst_n     in   1                   async active-low reset
//  i_pll_locked     in   1                   PLL lock, already synchronised to i_clk
//  i_sw_reset_req   in   1                   1-cycle pulse: restart the whole sequence
//  i_stage_ready    in   NUM_STAGES          per-stage ready, synchronous to i_clk
//  o_stage_rst      out  NUM_STAGES          per-stage reset hold, 1 = hold in reset
//  o_all_ready      out  1                   every stage released and ready
//  o_fault          out  1                   sticky fault flag
//  o_fault_stage    out  $clog2(NUM_STAGES)  index of the faulting stage (width 1 when NUM_STAGES=1)
//  o_busy           out  1                   sequence in progress (not DONE, not FAULT)
// BEHAVIOUR
//  Reset values (i_ext_arst_n=0): o_stage_rst all 1, o_all_ready 0, o_fault 0, o_fault_stage 0, o_busy 1, state WAIT_LOCK.
//  All outputs are registered.
//  Lock filter counter:
//  - increments while i_pll_locked=1; cleared whenever i_pll_locked=0.
//  - lock_ok = (count == LOCK_FILTER_CLKS); the counter saturates at that value.
//  States:
//  - WAIT_LOCK: all resets asserted. When lock_ok -> SETTLE, clearing the timer.
//  - SETTLE: count SETTLE_CLKS cycles, then -> RELEASE with stg=0. SETTLE_CLKS=0 passes straight through in 1 cycle.
//  - RELEASE: deassert o_stage_rst[stg] (bit falls on the next edge), clear timer -> WAIT_RDY.
//  - WAIT_RDY: when i_stage_ready[stg]=1:
//    - if stg==NUM_STAGES-1 -> DONE;
//    - else stg++ and -> RELEASE.
//    - A ready sampled 1 on the first WAIT_RDY cycle is accepted, so there is a minimum of 2 cycles per stage.
//  - WAIT_RDY timeout: if the timer reaches TIMEOUT_CLKS with no ready -> FAULT, o_fault_stage=stg.
//  - DONE: o_all_ready=1, o_busy=0. If any i_stage_ready bit drops -> FAULT with o_fault_stage = lowest dropped index.
//  - FAULT: all o_stage_rst=1, o_fault=1, o_busy=0. Leave only on i_sw_reset_req or i_ext_arst_n=0.
//  Global overrides, evaluated in every state, in priority order:
//  1. i_pll_locked=0 in any state except WAIT_LOCK/FAULT: next edge sets all o_stage_rst=1, o_all_ready=0, clears the lock counter, -> WAIT_LOCK.
//  2. i_sw_reset_req=1: same as 1 and also clears o_fault/o_fault_stage -> WAIT_LOCK. It wins over a simultaneous ready or timeout.
//  - Loss of lock in FAULT does not clear the fault.
//  Release ordering:
//  - stage k is never released while any stage j<k is in reset;
//  - once released, a stage is re-asserted only by an override or by FAULT.
//  - Already-released stages stay released during later stages' WAIT_RDY.
//  - Ready bits of unreleased stages are ignored.
//  Arithmetic:
//  - timer width $clog2(max(TIMEOUT_CLKS,SETTLE_CLKS)+1), saturating, never wraps;
//  - stage index width $clog2(NUM_STAGES), never exceeds NUM_STAGES-1.
//  Async reset mid-sequence returns everything to the reset values immediately. No partial state survives.
// STRUCTURE
//  Package reset_seq_pkg:
//  - typedef enum logic [2:0] rst_seq_state_t {WAIT_LOCK, SETTLE, RELEASE, WAIT_RDY, DONE, FAULT};
//  - localparam MAX_STAGES=16.
//  Sub-module reset_seq_lock_filter: saturating consecutive-lock counter that outputs lock_ok.
//  Top level holds the FSM, timer and stage index.
// TESTING
//  T1 (NUM_STAGES=4, LOCK=8, SETTLE=16): lock steady, each stage ready 5 clk after its release.
//     -> o_stage_rst bits fall in order 0..3, 6 clk apart; o_all_ready=1 two clk after ready[3]; o_fault=0.
//  T2: lock toggles 1,1,1,0 then holds 1.
//     -> no release before 8 consecutive locked cycles; stage 0 released 8+16+2 clk after the final rise.
//  T3 (TIMEOUT=100): stage 2 never readies.
//     -> o_fault=1, o_fault_stage=2, all resets re-asserted at cycle 100 of WAIT_RDY;
//     -> the fault clears only after an i_sw_reset_req pulse.
//  T4: in DONE, drop i_pll_locked for 1 cycle.
//     -> all o_stage_rst=1 and o_all_ready=0 the next edge; full sequence re-runs; o_fault stays 0.
//  T5: in DONE, drop i_stage_ready[1] and [3] together.
//     -> o_fault=1, o_fault_stage=1; then i_sw_reset_req and a timeout in the same cycle -> sw request wins, fault cleared.
//  T6: assert i_ext_arst_n=0 mid WAIT_RDY of stage 1.
//     -> outputs return to reset values asynchronously; sequence restarts from WAIT_LOCK on release.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer slice.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        RELEASE,
        WAIT_RDY,
        DONE,
        FAULT
    } rst_seq_state_t;

    localparam int MAX_STAGES = 16;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_lock_filter.sv
// Accepts PLL lock only after LOCK_FILTER_CLKS consecutive locked cycles.
module reset_seq_lock_filter
    import reset_seq_pkg::*;
#(
    parameter int LOCK_FILTER_CLKS = 8
) (
    input  logic i_clk,
    input  logic i_ext_arst_n,
    input  logic i_pll_locked,
    input  logic i_clear,
    output logic o_lock_ok
);

    localparam int CNT_W = width_for(LOCK_FILTER_CLKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER_CLKS);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at CNT_MAX so lock_ok stays asserted while lock holds.
    always_ff @(posedge i_clk or negedge i_ext_arst_n) begin
        if (!i_ext_arst_n) begin
            cnt_q <= '0;
        end else if (i_clear || !i_pll_locked) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_lock_ok = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain reset holds in order once PLL lock is trusted,
// re-entering full reset on lock loss or software request.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES       = 4,
    parameter int LOCK_FILTER_CLKS = 8,
    parameter int SETTLE_CLKS      = 16,
    parameter int TIMEOUT_CLKS     = 65535
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_ext_arst_n,
    input  logic                                                 i_pll_locked,
    input  logic                                                 i_sw_reset_req,
    input  logic [NUM_STAGES-1:0]                                i_stage_ready,
    output logic [NUM_STAGES-1:0]                                o_stage_rst,
    output logic                                                 o_all_ready,
    output logic                                                 o_fault,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] o_fault_stage,
    output logic                                                 o_busy
);

    localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int TMR_W = width_for(max_int(TIMEOUT_CLKS, SETTLE_CLKS));

    localparam logic [STG_W-1:0] LAST_STG  = STG_W'(NUM_STAGES - 1);
    localparam logic [TMR_W-1:0] SETTLE_T  = TMR_W'(SETTLE_CLKS);
    localparam logic [TMR_W-1:0] TIMEOUT_T = TMR_W'(TIMEOUT_CLKS - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be 1..%0d", MAX_STAGES);
    end
    if (LOCK_FILTER_CLKS < 1 || TIMEOUT_CLKS < 1 || SETTLE_CLKS < 0) begin : g_bad_timing
        $error("reset_sequencer: timing parameter out of range");
    end

    rst_seq_state_t         state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic [NUM_STAGES-1:0]  rst_q, rst_d;
    logic                   all_rdy_q, all_rdy_d;
    logic                   fault_q, fault_d;
    logic [STG_W-1:0]       fstg_q, fstg_d;
    logic                   busy_q, busy_d;
    logic                   lock_ok;
    logic                   lock_clr;
    logic                   restart;

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    function automatic logic [STG_W-1:0] lowest_clear(input logic [NUM_STAGES-1:0] v);
        logic [STG_W-1:0] idx;
        idx = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!v[i]) idx = STG_W'(i);
        end
        return idx;
    endfunction

    reset_seq_lock_filter #(
        .LOCK_FILTER_CLKS (LOCK_FILTER_CLKS)
    ) u_lock_filter (
        .i_clk        (i_clk),
        .i_ext_arst_n (i_ext_arst_n),
        .i_pll_locked (i_pll_locked),
        .i_clear      (lock_clr),
        .o_lock_ok    (lock_ok)
    );

    // Lock loss is ignored in WAIT_LOCK (nothing released) and FAULT (fault must persist).
    assign restart = i_sw_reset_req ||
                     (!i_pll_locked && state_q != WAIT_LOCK && state_q != FAULT);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        stg_d     = stg_q;
        rst_d     = rst_q;
        all_rdy_d = 1'b0;
        fault_d   = fault_q;
        fstg_d    = fstg_q;
        busy_d    = 1'b1;
        lock_clr  = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                rst_d = '1;
                if (lock_ok) begin
                    state_d = SETTLE;
                    timer_d = '0;
                end
            end
            SETTLE: begin
                rst_d = '1;
                if (timer_q == SETTLE_T) begin
                    state_d = RELEASE;
                    stg_d   = '0;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            RELEASE: begin
                rst_d[stg_q] = 1'b0;
                timer_d      = '0;
                state_d      = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (i_stage_ready[stg_q]) begin
                    if (stg_q == LAST_STG) begin
                        state_d = DONE;
                    end else begin
                        stg_d   = stg_q + 1'b1;
                        state_d = RELEASE;
                    end
                end else if (timer_q == TIMEOUT_T) begin
                    state_d = FAULT;
                    rst_d   = '1;
                    fault_d = 1'b1;
                    fstg_d  = stg_q;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            DONE: begin
                all_rdy_d = 1'b1;
                busy_d    = 1'b0;
                if (!(&i_stage_ready)) begin
                    state_d   = FAULT;
                    rst_d     = '1;
                    all_rdy_d = 1'b0;
                    fault_d   = 1'b1;
                    fstg_d    = lowest_clear(i_stage_ready);
                end
            end
            FAULT: begin
                rst_d  = '1;
                busy_d = 1'b0;
            end
            default: begin
                state_d = WAIT_LOCK;
                rst_d   = '1;
            end
        endcase

        // Overrides win over any ready/timeout decision taken above.
        if (restart) begin
            state_d   = WAIT_LOCK;
            timer_d   = '0;
            stg_d     = '0;
            rst_d     = '1;
            all_rdy_d = 1'b0;
            busy_d    = 1'b1;
            lock_clr  = 1'b1;
            if (i_sw_reset_req) begin
                fault_d = 1'b0;
                fstg_d  = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_ext_arst_n) begin
        if (!i_ext_arst_n) begin
            state_q   <= WAIT_LOCK;
            timer_q   <= '0;
            stg_q     <= '0;
            rst_q     <= '1;
            all_rdy_q <= 1'b0;
            fault_q   <= 1'b0;
            fstg_q    <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stg_q     <= stg_d;
            rst_q     <= rst_d;
            all_rdy_q <= all_rdy_d;
            fault_q   <= fault_d;
            fstg_q    <= fstg_d;
            busy_q    <= busy_d;
        end
    end

    assign o_stage_rst   = rst_q;
    assign o_all_ready   = all_rdy_q;
    assign o_fault       = fault_q;
    assign o_fault_stage = fstg_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release-order scoreboard plus status checks.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       sw;
    logic [3:0] ready;
    logic [3:0] stage_rst;
    logic       all_ready;
    logic       fault;
    logic [1:0] fault_stage;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_r;
    logic       mon_en   = 1'b0;
    logic [3:0] prev_rst = 4'hF;

    typedef struct {
        string      tag;
        logic [3:0] rst;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    reset_sequencer #(
        .NUM_STAGES       (4),
        .LOCK_FILTER_CLKS (8),
        .SETTLE_CLKS      (16),
        .TIMEOUT_CLKS     (100)
    ) dut (
        .i_clk          (clk),
        .i_ext_arst_n   (rst_n),
        .i_pll_locked   (locked),
        .i_sw_reset_req (sw),
        .i_stage_ready  (ready),
        .o_stage_rst    (stage_rst),
        .o_all_ready    (all_ready),
        .o_fault        (fault),
        .o_fault_stage  (fault_stage),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push(input string tag, input logic [3:0] rst_v, input int at_cyc);
        exp_t e;
        e.tag = tag;
        e.rst = rst_v;
        e.cyc = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expects stage 0 release 26 clk after the first edge of a stable lock run,
    // then readies stages 0..nrdy-1, each d clk after its release.
    task automatic run_seq(input string tg, input int rise, input int nrdy, input int d);
        int r;
        r = rise + 26;
        for (int k = 0; k < 4; k++) begin
            push($sformatf("%s rel%0d", tg, k), 4'(4'hF << (k + 1)), r);
            if (k >= nrdy) break;
            tick_to(r + d - 1);
            ready[k] = 1'b1;
            r = r + d + 1;
        end
        last_r = r;
    endtask

    // Every change of o_stage_rst must match the next predicted event, value and cycle.
    always @(negedge clk) begin
        if (mon_en && (stage_rst !== prev_rst)) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_rst_change: observed %0h expected %0h at cycle %0d",
                       stage_rst, prev_rst, cyc);
            end
            if (exp_q.size() != 0) begin
                chk({exp_q[0].tag, " value"}, 32'(stage_rst), 32'(exp_q[0].rst));
                chk({exp_q[0].tag, " cycle"}, cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            prev_rst <= stage_rst;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        sw     = 1'b0;
        ready  = 4'h0;
        tick(3);
        chk("reset stage_rst", 32'(stage_rst), 32'hF);
        chk("reset all_ready", 32'(all_ready), 0);
        chk("reset fault", 32'(fault), 0);
        chk("reset fault_stage", 32'(fault_stage), 0);
        chk("reset busy", 32'(busy), 1);
        mon_en = 1'b1;

        // T1: steady lock, each stage ready 5 clk after release
        rst_n  = 1'b1;
        locked = 1'b1;
        run_seq("T1", cyc + 1, 4, 5);
        chk("T1 busy mid", 32'(busy), 1);
        tick_to(last_r - 1);
        chk("T1 all_ready early", 32'(all_ready), 0);
        tick_to(last_r);
        chk("T1 all_ready", 32'(all_ready), 1);
        chk("T1 busy done", 32'(busy), 0);
        chk("T1 fault", 32'(fault), 0);

        // T4: one-cycle lock loss in DONE, ready held so each stage takes 2 clk
        locked = 1'b0;
        push("T4 lock_loss", 4'hF, cyc + 1);
        tick(1);
        locked = 1'b1;
        chk("T4 all_ready drop", 32'(all_ready), 0);
        chk("T4 busy", 32'(busy), 1);
        run_seq("T4", cyc + 1, 4, 1);
        tick_to(last_r);
        chk("T4 all_ready", 32'(all_ready), 1);
        chk("T4 fault", 32'(fault), 0);

        // T5: ready[1] and ready[3] drop together in DONE
        ready = 4'b0101;
        push("T5 drop", 4'hF, cyc + 1);
        tick(1);
        chk("T5 fault", 32'(fault), 1);
        chk("T5 fault_stage", 32'(fault_stage), 1);
        chk("T5 busy", 32'(busy), 0);
        chk("T5 all_ready", 32'(all_ready), 0);
        ready = 4'h0;
        sw    = 1'b1;
        tick(1);
        sw = 1'b0;
        chk("T5 sw clears fault", 32'(fault), 0);
        chk("T5 sw clears fault_stage", 32'(fault_stage), 0);
        chk("T5 busy after sw", 32'(busy), 1);

        // T3: stage 2 never readies
        run_seq("T3", cyc + 1, 2, 5);
        tick_to(last_r + 99);
        chk("T3 no fault at 99", 32'(fault), 0);
        push("T3 timeout", 4'hF, last_r + 100);
        tick_to(last_r + 100);
        chk("T3 fault", 32'(fault), 1);
        chk("T3 fault_stage", 32'(fault_stage), 2);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(2);
        chk("T3 fault kept on lock loss", 32'(fault), 1);
        chk("T3 fault_stage kept", 32'(fault_stage), 2);
        ready = 4'h0;
        sw    = 1'b1;
        tick(1);
        sw = 1'b0;
        chk("T3 sw clears fault", 32'(fault), 0);

        // T5b: sw request lands in the same cycle as the stage-2 timeout
        run_seq("T5b", cyc + 1, 2, 2);
        tick_to(last_r + 99);
        sw = 1'b1;
        push("T5b sw_vs_timeout", 4'hF, last_r + 100);
        tick(1);
        sw = 1'b0;
        chk("T5b fault", 32'(fault), 0);
        chk("T5b busy", 32'(busy), 1);
        tick(1);
        chk("T5b fault later", 32'(fault), 0);

        // T2: lock 1,1,1,0 then steady
        ready  = 4'h0;
        locked = 1'b0;
        tick(2);
        locked = 1'b1;
        tick(3);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        run_seq("T2", cyc + 1, 1, 3);

        // T6: async reset in WAIT_RDY of stage 1
        tick_to(last_r + 2);
        #2;
        push("T6 arst", 4'hF, cyc);
        rst_n = 1'b0;
        #1;
        chk("T6 async stage_rst", 32'(stage_rst), 32'hF);
        chk("T6 async all_ready", 32'(all_ready), 0);
        chk("T6 async fault", 32'(fault), 0);
        chk("T6 async busy", 32'(busy), 1);
        ready = 4'h0;
        tick(2);
        rst_n = 1'b1;
        run_seq("T6", cyc + 1, 4, 1);
        tick_to(last_r);
        chk("T6 all_ready", 32'(all_ready), 1);
        chk("T6 fault", 32'(fault), 0);
        chk("T6 fault_stage", 32'(fault_stage), 0);

        tick(2);
        chk("expected events drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
